// File: rtl/anita_scaler_pkg.sv
// Shared sizing helpers, status word layout and configuration check for the
// TURF scaler bank.
package anita_scaler_pkg;

    localparam int GATE_TIMEOUT_DEF = 34000000;
    localparam int STAT_TMO_BIT     = 0;
    localparam int STAT_SEQ_LSB     = 16;
    localparam int SEQ_W            = 16;

    function automatic int calc_nw(input int num_ch, input int width);
        return num_ch * width / 32;
    endfunction

    function automatic int calc_no(input int num_ch);
        return num_ch / 32;
    endfunction

    function automatic bit cfg_ok(input int num_ch, input int width, input int prescale);
        return (num_ch > 0) && (num_ch % 32 == 0) &&
               (width == 8 || width == 16 || width == 32) &&
               (prescale >= 0) && (prescale <= 8);
    endfunction

endpackage

// File: rtl/anita_scaler_ch.sv
// One scaler channel: rising-edge detect, prescaler, saturating counter and
// gate-latched hold/overflow registers.
module anita_scaler_ch #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 0
) (
    input  logic             clk33_i,
    input  logic             rst_i,
    input  logic             trig,
    input  logic             gate,
    output logic [WIDTH-1:0] hold,
    output logic             ovf_hold
);

    localparam int PW = (PRESCALE > 0) ? PRESCALE : 1;

    logic             r1, r2;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] count;
    logic             ovf;
    logic             trig_edge;
    logic             wrap;

    assign trig_edge = r1 & ~r2;
    assign wrap      = (PRESCALE == 0) || (presc == '1);

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            r1       <= 1'b0;
            r2       <= 1'b0;
            presc    <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            hold     <= '0;
            ovf_hold <= 1'b0;
        end else begin
            r1 <= trig;
            r2 <= r1;
            if (gate) begin
                hold     <= count;
                ovf_hold <= ovf;
                ovf      <= 1'b0;
                // an edge landing on the gate opens the new period
                if (PRESCALE == 0) begin
                    count <= WIDTH'(trig_edge);
                end else begin
                    count <= '0;
                    presc <= PW'(trig_edge);
                end
            end else if (trig_edge) begin
                if (PRESCALE != 0)
                    presc <= presc + 1'b1;
                if (wrap) begin
                    if (count == '1)
                        ovf <= 1'b1;
                    else
                        count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/anita_scaler_bank.sv
// Scaler bank top: PPS/timeout gate, period and sequence tracking, NUM_CH
// channel instances and the registered 32-bit readout mux.
module anita_scaler_bank
    import anita_scaler_pkg::*;
#(
    parameter int NUM_CH       = 64,
    parameter int WIDTH        = 16,
    parameter int PRESCALE     = 0,
    parameter int GATE_TIMEOUT = GATE_TIMEOUT_DEF,
    parameter int ADDR_W       = 8
) (
    input  logic              clk33_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] trig_i,
    input  logic              pps_i,
    input  logic [ADDR_W-1:0] scal_addr_i,
    output logic [31:0]       scal_dat_o,
    output logic              upd_o
);

    localparam int NW     = calc_nw(NUM_CH, WIDTH);
    localparam int NO     = calc_no(NUM_CH);
    localparam int A_PER  = NW + NO;
    localparam int A_STAT = NW + NO + 1;
    localparam logic [31:0] TMO_LAST = 32'(GATE_TIMEOUT - 1);

    if (!cfg_ok(NUM_CH, WIDTH, PRESCALE)) begin : g_bad_cfg
        $error("anita_scaler_bank: illegal NUM_CH/WIDTH/PRESCALE");
    end

    logic [1:0]                   pps_r;
    logic                         pps_edge;
    logic                         gate;
    logic [31:0]                  tmo_cnt;
    logic [31:0]                  period;
    logic [31:0]                  period_hold;
    logic [SEQ_W-1:0]             seq;
    logic                         tmo_hold;
    logic [NUM_CH-1:0][WIDTH-1:0] hold;
    logic [NUM_CH-1:0]            ovf_hold;
    logic [NW-1:0][31:0]          hold_w;
    logic [NO-1:0][31:0]          ovf_w;
    logic [31:0]                  addr;
    logic [31:0]                  rd;

    assign pps_edge = pps_r[0] & ~pps_r[1];
    assign gate     = pps_edge | (tmo_cnt == TMO_LAST);

    // channel k sits at bit WIDTH*k of the flat hold vector, which is
    // exactly the word/lane packing seen on the readout bus
    assign hold_w = hold;
    assign ovf_w  = ovf_hold;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        anita_scaler_ch #(
            .WIDTH    (WIDTH),
            .PRESCALE (PRESCALE)
        ) u_ch (
            .clk33_i  (clk33_i),
            .rst_i    (rst_i),
            .trig     (trig_i[k]),
            .gate     (gate),
            .hold     (hold[k]),
            .ovf_hold (ovf_hold[k])
        );
    end

    always_comb begin
        addr = 32'(scal_addr_i);
        rd   = '0;
        for (int i = 0; i < NW; i++)
            if (addr == 32'(i)) rd = hold_w[i];
        for (int i = 0; i < NO; i++)
            if (addr == 32'(NW + i)) rd = ovf_w[i];
        if (addr == 32'(A_PER))
            rd = period_hold;
        if (addr == 32'(A_STAT)) begin
            rd[STAT_SEQ_LSB +: SEQ_W] = seq;
            rd[STAT_TMO_BIT]          = tmo_hold;
        end
    end

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            pps_r       <= '0;
            tmo_cnt     <= '0;
            period      <= '0;
            period_hold <= '0;
            seq         <= '0;
            tmo_hold    <= 1'b0;
            upd_o       <= 1'b0;
            scal_dat_o  <= '0;
        end else begin
            pps_r      <= {pps_r[0], pps_i};
            upd_o      <= gate;
            scal_dat_o <= rd;
            if (gate) begin
                tmo_cnt     <= '0;
                period_hold <= (period == '1) ? '1 : period + 1'b1;
                period      <= '0;
                seq         <= seq + 1'b1;
                tmo_hold    <= ~pps_edge;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (period != '1)
                    period <= period + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_anita_scaler_bank.sv
// Bench for anita_scaler_bank: instance A (defaults, short timeout) is checked
// every cycle against an edge-counting model; B (WIDTH=8) and C (PRESCALE=2)
// are checked with hand-computed reads.
module tb_anita_scaler_bank;

    localparam int GT_A = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, pps_a, upd_a;
    logic [63:0] trig_a;
    logic [7:0]  addr_a;
    logic [31:0] dat_a;

    logic         rst_bc, pps_bc, upd_b, upd_c;
    logic [7:0]   addr_bc;
    logic [127:0] trig_b;
    logic [63:0]  trig_c;
    logic [31:0]  dat_b, dat_c;

    anita_scaler_bank #(.NUM_CH(64), .WIDTH(16), .PRESCALE(0), .GATE_TIMEOUT(GT_A), .ADDR_W(8)) dut_a (
        .clk33_i(clk), .rst_i(rst_a), .trig_i(trig_a), .pps_i(pps_a),
        .scal_addr_i(addr_a), .scal_dat_o(dat_a), .upd_o(upd_a));

    anita_scaler_bank #(.NUM_CH(128), .WIDTH(8), .PRESCALE(0), .GATE_TIMEOUT(100000), .ADDR_W(8)) dut_b (
        .clk33_i(clk), .rst_i(rst_bc), .trig_i(trig_b), .pps_i(pps_bc),
        .scal_addr_i(addr_bc), .scal_dat_o(dat_b), .upd_o(upd_b));

    anita_scaler_bank #(.NUM_CH(64), .WIDTH(16), .PRESCALE(2), .GATE_TIMEOUT(100000), .ADDR_W(8)) dut_c (
        .clk33_i(clk), .rst_i(rst_bc), .trig_i(trig_c), .pps_i(pps_bc),
        .scal_addr_i(addr_bc), .scal_dat_o(dat_c), .upd_o(upd_c));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of instance A: edges are integers per period, holds are the
    // saturated totals, everything else is plain bookkeeping per gate.
    logic [63:0] m_h1, m_h2;
    logic        m_p1, m_p2;
    int          m_n[64];
    logic [15:0] m_hold[64];
    bit          m_ovfh[64];
    longint      m_period;
    logic [31:0] m_phold;
    int          m_tcnt;
    logic [15:0] m_seq;
    bit          m_tmoh;
    bit          m_upd;
    logic [31:0] m_dat;

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] r;
        r = '0;
        if (a < 32) r = {m_hold[2*a+1], m_hold[2*a]};
        else if (a < 34) for (int b = 0; b < 32; b++) r[b] = m_ovfh[32*(a-32)+b];
        else if (a == 34) r = m_phold;
        else if (a == 35) r = {m_seq, 15'b0, m_tmoh};
        return r;
    endfunction

    task automatic m_clear();
        m_h1 = '0; m_h2 = '0; m_p1 = 1'b0; m_p2 = 1'b0;
        for (int c = 0; c < 64; c++) begin m_n[c] = 0; m_hold[c] = '0; m_ovfh[c] = 1'b0; end
        m_period = 0; m_phold = '0; m_tcnt = 0; m_seq = '0; m_tmoh = 1'b0;
        m_upd = 1'b0; m_dat = '0;
    endtask

    initial begin : model
        logic [63:0] e;
        bit pe, g;
        m_clear();
        forever begin
            @(negedge clk);
            chk("upd_a", {31'b0, upd_a}, {31'b0, m_upd});
            chk("dat_a", dat_a, m_dat);
            if (rst_a) begin
                m_clear();
            end else begin
                e  = m_h1 & ~m_h2;
                pe = m_p1 & ~m_p2;
                g  = pe || (m_tcnt == GT_A - 1);
                m_dat = m_read(int'(addr_a));
                m_upd = g;
                if (g) begin
                    for (int c = 0; c < 64; c++) begin
                        m_hold[c] = (m_n[c] > 65535) ? 16'hFFFF : 16'(m_n[c]);
                        m_ovfh[c] = (m_n[c] > 65535);
                        m_n[c]    = int'(e[c]);
                    end
                    m_phold  = (m_period + 1 > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(m_period + 1);
                    m_period = 0;
                    m_seq    = m_seq + 16'd1;
                    m_tmoh   = !pe;
                    m_tcnt   = 0;
                end else begin
                    for (int c = 0; c < 64; c++) m_n[c] += int'(e[c]);
                    if (m_period < 64'hFFFFFFFF) m_period++;
                    m_tcnt++;
                end
                m_h2 = m_h1; m_h1 = trig_a;
                m_p2 = m_p1; m_p1 = pps_a;
            end
        end
    end

    int n_upd_b = 0, n_upd_c = 0;
    initial forever begin
        @(negedge clk);
        if (upd_b === 1'b1) n_upd_b++;
        if (upd_c === 1'b1) n_upd_c++;
    end

    // One PPS period on A: PPS high 5 cycles, pulses every other cycle from
    // cycle 2, optional ch2 pulse coincident with the PPS rise.
    task automatic do_period(input int n0, input int n63, input int len, input bit co2);
        for (int c = 0; c < len; c++) begin
            pps_a  = (c < 5);
            trig_a = '0;
            addr_a = 8'(c % 40);
            if (c == 0 && co2) trig_a[2] = 1'b1;
            if (c >= 2 && (c % 2 == 0)) begin
                trig_a[0]  = ((c - 2) / 2) < n0;
                trig_a[63] = ((c - 2) / 2) < n63;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_a(input int len);
        for (int c = 0; c < len; c++) begin
            pps_a = 1'b0; trig_a = '0; addr_a = 8'(c % 40);
            @(posedge clk); #1;
        end
    endtask

    task automatic read_a(input int a, input logic [31:0] mask, input logic [31:0] exp, input string name);
        addr_a = 8'(a);
        @(posedge clk); #1;
        chk(name, dat_a & mask, exp);
    endtask

    task automatic per_bc(input int n5, input int n1, input bit co1, input int len);
        for (int c = 0; c < len; c++) begin
            pps_bc = (c < 5);
            trig_b = '0;
            trig_c = '0;
            if (c == 0 && co1) trig_c[1] = 1'b1;
            if (c >= 2 && (c % 2 == 0)) begin
                trig_b[5] = ((c - 2) / 2) < n5;
                trig_c[1] = ((c - 2) / 2) < n1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic read_bc(input bit sel_c, input int a, input logic [31:0] mask,
                           input logic [31:0] exp, input string name);
        addr_bc = 8'(a);
        @(posedge clk); #1;
        chk(name, (sel_c ? dat_c : dat_b) & mask, exp);
    endtask

    initial begin
        rst_a = 1'b1; rst_bc = 1'b1;
        trig_a = '0; pps_a = 1'b0; addr_a = '0;
        trig_b = '0; trig_c = '0; pps_bc = 1'b0; addr_bc = '0;
        repeat (2) @(posedge clk);
        #1;
        read_a(35, 32'hFFFFFFFF, 32'h0, "rst_stat");
        rst_a = 1'b0; rst_bc = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // normal PPS operation
        do_period(37, 200, 500, 1'b0);
        do_period(0, 0, 500, 1'b0);
        chk("model_hold0", 32'(m_hold[0]), 32'd37);
        chk("model_hold63", 32'(m_hold[63]), 32'd200);
        chk("model_phold", m_phold, 32'd500);
        read_a(0, 32'h0000FFFF, 32'd37, "ch0_cnt");
        read_a(31, 32'hFFFF0000, 32'h00C80000, "ch63_cnt");
        read_a(34, 32'hFFFFFFFF, 32'd500, "period_pps");
        read_a(35, 32'hFFFFFFFF, 32'h00020000, "stat_seq2");
        read_a(33, 32'hFFFFFFFF, 32'h0, "ovf_none");
        read_a(36, 32'hFFFFFFFF, 32'h0, "unmapped36");
        read_a(200, 32'hFFFFFFFF, 32'h0, "unmapped200");

        // PPS removed: internal timeout gates
        idle_a(2500);
        chk("model_tmo", {31'b0, m_tmoh}, 32'd1);
        read_a(35, 32'h1, 32'h1, "tmo_flag");
        read_a(34, 32'hFFFFFFFF, 32'd1000, "period_tmo");
        do_period(0, 0, 500, 1'b0);
        read_a(35, 32'h1, 32'h0, "tmo_cleared");

        // edge coincident with the PPS edge goes to the new period
        do_period(0, 0, 500, 1'b1);
        read_a(1, 32'h0000FFFF, 32'h0, "coinc_closing");
        do_period(0, 0, 500, 1'b0);
        read_a(1, 32'h0000FFFF, 32'h1, "coinc_next");

        // reset mid-period with ch7 held high across release
        do_period(20, 20, 100, 1'b0);
        trig_a = '0; trig_a[7] = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_a = 1'b0;
        read_a(0, 32'hFFFFFFFF, 32'h0, "rst_w0");
        read_a(31, 32'hFFFFFFFF, 32'h0, "rst_w31");
        read_a(34, 32'hFFFFFFFF, 32'h0, "rst_period");
        read_a(35, 32'hFFFFFFFF, 32'h0, "rst_stat2");
        do_period(0, 0, 500, 1'b0);
        read_a(3, 32'hFFFF0000, 32'h00010000, "held_high_1");

        // WIDTH=8 saturation (B) and PRESCALE=2 carry (C)
        per_bc(300, 10, 1'b0, 700);
        per_bc(10, 3, 1'b0, 700);
        read_bc(1'b0, 1, 32'h0000FF00, 32'h0000FF00, "b_sat");
        read_bc(1'b0, 32, 32'h00000020, 32'h00000020, "b_ovf_set");
        read_bc(1'b0, 36, 32'hFFFFFFFF, 32'd700, "b_period");
        read_bc(1'b1, 0, 32'hFFFF0000, 32'h00020000, "c_presc10");
        per_bc(0, 3, 1'b1, 700);
        read_bc(1'b0, 1, 32'h0000FF00, 32'h00000A00, "b_cnt10");
        read_bc(1'b0, 32, 32'h00000020, 32'h0, "b_ovf_clr");
        read_bc(1'b1, 0, 32'hFFFF0000, 32'h0, "c_presc3");
        per_bc(0, 0, 1'b0, 700);
        read_bc(1'b1, 0, 32'hFFFF0000, 32'h00010000, "c_carry");
        read_bc(1'b0, 37, 32'hFFFFFFFF, 32'h00040000, "b_stat");
        chk("b_upd_cnt", 32'(n_upd_b), 32'd4);
        chk("c_upd_cnt", 32'(n_upd_c), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/anita_scaler_bank.md
Name: anita_scaler_bank

Overview:
- Parametrised scaler bank for the TURF trigger path; successor to the fixed L1/L3 scaler set.
- Edge-counts NUM_CH trigger lines over a gate period delimited by PPS, or by an internal timeout when PPS is absent.
- Latches the counts into hold registers and serves them, with overflow flags, period length and status, on a registered 32-bit readout bus.

Parameters:
- NUM_CH, 64, number of counted channels; multiple of 32.
- WIDTH, 16, counter and hold width per channel; one of 8, 16, 32.
- PRESCALE, 0, counter advances once per 2^PRESCALE input edges; 0..8.
- GATE_TIMEOUT, 34000000, clock cycles without a PPS edge before an internal gate fires.
- ADDR_W, 8, readout address width.

Ports:
- clk33_i  in  1  system clock, 33 MHz.
- rst_i  in  1  synchronous reset, active-high.
- trig_i  in  NUM_CH  trigger lines, already synchronous to clk33_i.
- pps_i  in  1  PPS level, synchronous to clk33_i.
- scal_addr_i  in  ADDR_W  readout word address.
- scal_dat_o  out  32  readout data.
- upd_o  out  1  one-cycle pulse when the hold registers update.

Behaviour:
- Reset values, one cycle after rst_i is sampled high: all counters, prescalers, holds, overflow flags, period, seq and timeout flag = 0; scal_dat_o = 0; upd_o = 0; all edge registers = 0.
- Edge detect: each trig_i bit passes through 2 registers; edge = r1 & ~r2.
  - A line held high through reset release counts exactly one edge.
- PPS edge uses the same 2-register scheme.
- Gate event, G: PPS edge, OR timeout counter == GATE_TIMEOUT-1.
  - The timeout counter clears on every G.
- Per channel at G:
  - hold <= count; ovf_hold <= ovf.
  - An edge coincident with G belongs to the new period: count <= 0, prescaler <= (edge ? 1 : 0), ovf <= 0. Same carry rule if PRESCALE = 0: count <= edge.
- Per channel, non-G cycle: on edge, prescaler increments.
  - On prescaler wrap (2^PRESCALE edges), count increments.
  - Saturation: at all-ones, count holds and ovf <= 1; no wrap.
- Period counter counts clocks since the last G and saturates at 0xFFFFFFFF. At G, period_hold <= period + 1 and period <= 0.
- At G:
  - seq increments, 16-bit, wrapping.
  - tmo_hold <= 1 if G came from the timeout and not from PPS; PPS wins when both coincide.
- upd_o: asserted the cycle after G, i.e. the same cycle the new holds are visible.
- Address map, with NW = NUM_CH*WIDTH/32 and NO = NUM_CH/32:
  - 0..NW-1: scalers, packed 32/WIDTH per word, channel k at word k/(32/WIDTH), bits WIDTH*(k%(32/WIDTH)) +: WIDTH.
  - NW..NW+NO-1: ovf_hold, channel k at word NW+k/32, bit k%32.
  - NW+NO: period_hold.
  - NW+NO+1: {seq[15:0], 15'b0, tmo_hold}.
  - All other addresses: 0.
- Readout latency: scal_dat_o is registered and reflects scal_addr_i sampled on the previous edge.
- A multi-word read spanning an update may tear. Software re-reads seq before and after to detect it; no freeze is provided.
- Reset mid-period: all state clears and no upd_o pulse is produced. The first G after reset reports a partial period.

Decomposition:
- Package anita_scaler_pkg holds:
  - functions for NW/NO;
  - status bit positions;
  - the GATE_TIMEOUT default;
  - an elaboration check on legal WIDTH/NUM_CH/PRESCALE.
- Sub-module anita_scaler_ch: one channel containing edge detect, prescaler, saturating counter, hold and ovf flags, with inputs clk33_i, rst_i, trig, gate.
  - Generated NUM_CH times.
  - The top level holds gate/timeout, period, seq and the readout mux.

Test Plan:
- Defaults, GATE_TIMEOUT=1000, PPS every 500 cycles, 37 edges on ch0 and 200 on ch63 -> word 0 [15:0]=37; word 31 [31:16]=200; word 34 = 500; upd_o one pulse per PPS; seq +1 each time.
- PPS removed -> G every 1000 cycles; word 35 bit0=1 and period=1000. PPS restored -> bit0=0 at the next update.
- WIDTH=8, 300 edges on ch5 in one period -> word 1 [15:8]=0xFF; word 32 bit5=1. Following period with 10 edges -> 0x0A, ovf bit5=0.
- Edge on ch2 in the same cycle as a PPS edge -> excluded from the closing hold and counted as 1 in the next period.
- PRESCALE=2, 10 edges on ch1 in a period -> hold=2. With 3 edges in the next period plus 1 coincident with the following G -> that period reports 0 and the prescaler starts at 1.
- rst_i asserted mid-period with counts non-zero -> all addresses read 0 two cycles after; no upd_o; trig_i held high across release -> count 1 in the next hold.
